instruction_memory: RTL and testbench

Word-organised instruction store that answers the fetch stage: samples the fetch address every cycle and returns the addressed instruction word one clock later, registered. Also contains a serial byte loader that fills the store from a host/debug port before or between program runs. Sits directly opposite the fetch stage on its `pc`/`instr` interface.

---
 rtl/instruction_memory.sv | 159 +++++++++++++++
 tb/tb_instruction_memory.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory
// Purpose  : Registered word-organised instruction store with a serial byte
//            loader. Optional read parity via `INSTR_MEM_PARITY_EN.
// Revision : 1.0
// ============================================================================
module instruction_memory #(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic        fault_o,
    input  logic        load_start_i,
    input  logic        load_valid_i,
    input  logic [7:0]  load_byte_i,
    input  logic        load_last_i,
    output logic        load_ready_o,
    output logic        busy_o,
    output logic        overflow_o,
    output logic        parity_err_o
);
    localparam int ADDR_W = $clog2(DEPTH);
`ifdef INSTR_MEM_PARITY_EN
    localparam int MEM_W = 33;
`else
    localparam int MEM_W = 32;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [MEM_W-1:0]   mem [DEPTH];
    logic [1:0]         byte_idx;
    logic [ADDR_W:0]    word_addr;
    logic [31:0]        asm_word;
    logic [31:0]        asm_next;
    logic               accept;
    logic               word_done;
    logic               in_range;
    logic               wr_en;
    logic [31:0]        wr_data;
    logic [ADDR_W-1:0]  rd_idx;
    logic               rd_fault;
    logic [MEM_W-1:0]   rd_word;

    assign accept    = (state == ST_LOAD) && load_valid_i;
    assign word_done = accept && (byte_idx == 2'd3);
    // word_addr reaching DEPTH means the image has run past the store
    assign in_range  = ~word_addr[ADDR_W];
    assign wr_en     = in_range && (word_done || (state == ST_FLUSH));
    assign wr_data   = (state == ST_FLUSH) ? asm_word : asm_next;

    always_comb begin
        asm_next = asm_word;
        asm_next[8*byte_idx +: 8] = load_byte_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        busy_o       = 1'b0;
        load_ready_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start_i) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy_o       = 1'b1;
                load_ready_o = 1'b1;
                if (accept && load_last_i)
                    state_next = (byte_idx == 2'd3) ? ST_IDLE : ST_FLUSH;
            end
            ST_FLUSH: begin
                busy_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= 2'd0;
            word_addr  <= '0;
            asm_word   <= 32'd0;
            overflow_o <= 1'b0;
        end else if ((state == ST_IDLE) && load_start_i) begin
            byte_idx   <= 2'd0;
            word_addr  <= '0;
            asm_word   <= 32'd0;
            overflow_o <= 1'b0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            if (!in_range) overflow_o <= 1'b1;
            if (byte_idx == 2'd3) begin
                asm_word <= 32'd0;
                if (in_range) word_addr <= word_addr + (ADDR_W+1)'(1);
            end else begin
                asm_word <= asm_next;
            end
        end
    end

    // Storage is deliberately not reset so an image survives rst_n
    always_ff @(posedge clk) begin
        if (wr_en) begin
`ifdef INSTR_MEM_PARITY_EN
            mem[word_addr[ADDR_W-1:0]] <= {^wr_data, wr_data};
`else
            mem[word_addr[ADDR_W-1:0]] <= wr_data;
`endif
        end
    end

    assign rd_idx   = pc_i[ADDR_W+1:2];
    assign rd_fault = (|pc_i[1:0]) || (|pc_i[31:ADDR_W+2]);
    assign rd_word  = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_o <= NOP_WORD;
            fault_o <= 1'b0;
        end else if (busy_o) begin
            instr_o <= NOP_WORD;
            fault_o <= 1'b0;
        end else if (rd_fault) begin
            instr_o <= NOP_WORD;
            fault_o <= 1'b1;
        end else begin
            instr_o <= rd_word[31:0];
            fault_o <= 1'b0;
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   parity_err_o <= 1'b0;
        else if (busy_o || rd_fault)  parity_err_o <= 1'b0;
        else                          parity_err_o <= ^rd_word;
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_memory
// Purpose  : Scoreboard bench for instruction_memory with a byte-image model.
// Revision : 1.0
// ============================================================================
module tb_instruction_memory;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic [31:0] instr_o;
    logic        fault_o;
    logic        load_start_i = 1'b0;
    logic        load_valid_i = 1'b0;
    logic [7:0]  load_byte_i = 8'd0;
    logic        load_last_i = 1'b0;
    logic        load_ready_o;
    logic        busy_o;
    logic        overflow_o;
    logic        parity_err_o;

    always #5 clk = ~clk;

    instruction_memory #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_i         (pc_i),
        .instr_o      (instr_o),
        .fault_o      (fault_o),
        .load_start_i (load_start_i),
        .load_valid_i (load_valid_i),
        .load_byte_i  (load_byte_i),
        .load_last_i  (load_last_i),
        .load_ready_o (load_ready_o),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o),
        .parity_err_o (parity_err_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
        logic        perr;
        logic        busy;
        logic        ready;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] model_mem [DEPTH];
    logic        model_bad [DEPTH];
    logic        model_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("instr", instr_o, e.instr);
            chk("fault", 32'(fault_o), 32'(e.fault));
            chk("parity_err", 32'(parity_err_o), 32'(e.perr));
            chk("busy", 32'(busy_o), 32'(e.busy));
            chk("load_ready", 32'(load_ready_o), 32'(e.ready));
            chk("overflow", 32'(overflow_o), 32'(e.ovf));
        end
    end

    function automatic exp_t idle_read(input logic [31:0] pc);
        exp_t e;
        int   idx;
        e = '0;
        e.instr = NOP;
        e.ovf = model_ovf;
        if (pc[1:0] != 2'd0 || pc >= 32'(4 * DEPTH)) begin
            e.fault = 1'b1;
        end else begin
            idx = int'(pc >> 2);
            e.instr = model_mem[idx];
            e.perr = model_bad[idx];
        end
        return e;
    endfunction

    function automatic exp_t busy_exp(input logic busy, input logic ready);
        exp_t e;
        e = '0;
        e.instr = NOP;
        e.busy = busy;
        e.ready = ready;
        e.ovf = model_ovf;
        return e;
    endfunction

    function automatic logic [31:0] rand_pc();
        int r;
        r = int'($urandom_range(99));
        if (r < 70)      return 32'($urandom_range(DEPTH - 1)) << 2;
        else if (r < 80) return 32'(4 * DEPTH);
        else             return $urandom;
    endfunction

    // Drive one cycle from a falling edge and queue the response due after the next rising edge
    task automatic step(input logic [31:0] pc, input logic st, input logic v,
                        input logic [7:0] b, input logic l, input exp_t e);
        pc_i = pc;
        load_start_i = st;
        load_valid_i = v;
        load_byte_i = b;
        load_last_i = l;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] pc);
        step(pc, 1'b0, 1'b0, 8'($urandom), 1'b0, idle_read(pc));
    endtask

    task automatic load_image(input logic [7:0] img[$], input int gap_pct, input logic [31:0] start_pc);
        int          n;
        exp_t        e;
        logic [31:0] w;
        logic        last;
        n = img.size();
        e = idle_read(start_pc);
        e.busy = 1'b1;
        e.ready = 1'b1;
        e.ovf = 1'b0;
        model_ovf = 1'b0;
        step(start_pc, 1'b1, 1'b0, 8'h00, 1'b0, e);
        // Reads are suppressed until the load ends, so the image can be applied now
        for (int i = 0; (4 * i < n) && (i < DEPTH); i++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < n) w[8*j +: 8] = img[4*i+j];
            model_mem[i] = w;
            model_bad[i] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            while (int'($urandom_range(99)) < gap_pct)
                step($urandom, 1'($urandom_range(1)), 1'b0, 8'($urandom),
                     1'($urandom_range(1)), busy_exp(1'b1, 1'b1));
            if (k >= 4 * DEPTH) model_ovf = 1'b1;
            last = (k == n - 1);
            if (last) e = busy_exp(n % 4 != 0, 1'b0);
            else      e = busy_exp(1'b1, 1'b1);
            step($urandom, 1'b0, 1'b1, img[k], last, e);
        end
        if (n % 4 != 0)
            step($urandom, 1'b0, 1'b0, 8'h00, 1'b0, busy_exp(1'b0, 1'b0));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : driver
        logic [7:0] img[$];
        exp_t       e;
        int         len;

        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = 32'd0;
            model_bad[i] = 1'b0;
        end

        #2;
        chk("rst_instr", instr_o, NOP);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_parity", 32'(parity_err_o), 32'd0);
        chk("rst_ready", 32'(load_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fetch(32'h2);

        img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load_image(img, 0, 32'h3);
        fetch(32'h0);
        fetch(32'h4);
        chk("word0_image", model_mem[0], 32'h1234_5678);
        chk("word1_image", model_mem[1], 32'hDEAD_BEEF);

        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        load_image(img, 0, 32'h1);
        fetch(32'h4);
        fetch(32'h0);

        fetch(32'h2);
        fetch(32'h10);
        fetch(32'hFFFF_FFFC);
        fetch(32'h8000_0000);

        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(8'h40 + i));
        load_image(img, 0, 32'h10);
        for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i));
        fetch(32'hC);

        for (int it = 0; it < 8; it++) begin
            len = int'($urandom_range(1, 20));
            img.delete();
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            load_image(img, 30, rand_pc());
            for (int f = 0; f < 12; f++) fetch(rand_pc());
        end

        // Reset in the middle of a load: loaded words must survive, partial word is dropped
        e = idle_read(32'h3);
        e.busy = 1'b1;
        e.ready = 1'b1;
        e.ovf = 1'b0;
        model_ovf = 1'b0;
        step(32'h3, 1'b1, 1'b0, 8'h00, 1'b0, e);
        step(32'h0, 1'b0, 1'b1, 8'h11, 1'b0, busy_exp(1'b1, 1'b1));
        step(32'h0, 1'b0, 1'b1, 8'h22, 1'b0, busy_exp(1'b1, 1'b1));
        load_valid_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_ready", 32'(load_ready_o), 32'd0);
        chk("abort_instr", instr_o, NOP);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i));

`ifdef INSTR_MEM_PARITY_EN
        dut.mem[1][3] = ~dut.mem[1][3];
        model_mem[1][3] = ~model_mem[1][3];
        model_bad[1] = 1'b1;
        fetch(32'h4);
        fetch(32'h0);
        fetch(32'h4);
`endif

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
